// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce, press-pulse and auto-repeat for board buttons
// Each button runs independently; only the sample-tick prescaler is shared.
module button_conditioner #(
  parameter int               N_BTN              = 4,
  parameter int               SAMPLE_DIV         = 100000,
  parameter int               DEBOUNCE_TICKS     = 20,
  parameter int               REPEAT_DELAY_TICKS = 500,
  parameter int               REPEAT_RATE_TICKS  = 100,
  parameter logic [N_BTN-1:0] REPEAT_MASK        = 4'b1100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_held
);

  localparam int PW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW   = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS
                                                                  : REPEAT_RATE_TICKS;
  localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

  localparam logic [PW-1:0] DIV_LAST   = PW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'((REPEAT_DELAY_TICKS > 0) ? REPEAT_DELAY_TICKS - 1 : 0);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_TICKS - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [N_BTN-1:0] sync_meta;
  logic [N_BTN-1:0] sync;
  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [DW-1:0]    db_cnt [N_BTN];
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] fire;
  state_t           state      [N_BTN];
  state_t           state_next [N_BTN];
  logic [RW-1:0]    rpt_cnt      [N_BTN];
  logic [RW-1:0]    rpt_cnt_next [N_BTN];

  assign tick = (pre_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
      pre_cnt   <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
      pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  // rise/fall flag the tick on which the debounced level is about to toggle
  always_comb begin
    rise = '0;
    fall = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (tick && (sync[i] != level[i]) && (db_cnt[i] == DEB_LAST)) begin
        rise[i] = ~level[i];
        fall[i] = level[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= ~level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // a debounced fall wins over a repeat pulse due on the same tick
  always_comb begin
    fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_next[i]   = state[i];
      rpt_cnt_next[i] = rpt_cnt[i];
      case (state[i])
        IDLE: begin
          rpt_cnt_next[i] = '0;
          if (rise[i] && REPEAT_MASK[i]) state_next[i] = DELAY;
        end
        DELAY: begin
          if (fall[i]) begin
            state_next[i]   = IDLE;
            rpt_cnt_next[i] = '0;
          end else if (tick) begin
            if (rpt_cnt[i] >= DELAY_LAST) begin
              fire[i]         = 1'b1;
              rpt_cnt_next[i] = '0;
              state_next[i]   = REPEAT;
            end else begin
              rpt_cnt_next[i] = rpt_cnt[i] + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (fall[i]) begin
            state_next[i]   = IDLE;
            rpt_cnt_next[i] = '0;
          end else if (tick) begin
            if (rpt_cnt[i] >= RATE_LAST) begin
              fire[i]         = 1'b1;
              rpt_cnt_next[i] = '0;
            end else begin
              rpt_cnt_next[i] = rpt_cnt[i] + 1'b1;
            end
          end
        end
        default: begin
          state_next[i]   = IDLE;
          rpt_cnt_next[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state[i]   <= IDLE;
        rpt_cnt[i] <= '0;
      end
    end else begin
      press <= rise | fire;
      for (int i = 0; i < N_BTN; i++) begin
        state[i]   <= state_next[i];
        rpt_cnt[i] <= rpt_cnt_next[i];
      end
    end
  end

  always_comb begin
    btn_held = '0;
    for (int i = 0; i < N_BTN; i++) btn_held[i] = (state[i] == REPEAT);
  end

  assign btn_level = level;
  assign btn_press = press;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and random checks of button_conditioner
// The reference tracks consecutive differing samples and ticks-since-press per button.
module tb_button_conditioner;

  localparam int         DIV  = 4;
  localparam int         DEB  = 3;
  localparam int         DLY  = 5;
  localparam int         RATE = 2;
  localparam logic [3:0] MASK = 4'b1100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'b0;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_held;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(4), .SAMPLE_DIV(DIV), .DEBOUNCE_TICKS(DEB),
    .REPEAT_DELAY_TICKS(DLY), .REPEAT_RATE_TICKS(RATE), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_held(btn_held)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         cnt_press [4];
  logic [3:0] held_seen = 4'b0;
  logic [3:0] prev_press = 4'b0;

  // reference state
  int         phase = 0;
  logic [3:0] s1 = 4'b0, s2 = 4'b0;
  int         run   [4];
  int         since [4];
  logic [3:0] m_level = 4'b0, m_press = 4'b0, m_held = 4'b0;

  always @(posedge clk) begin : model
    logic [3:0] sample;
    bit         tk;
    bit         rose;
    if (rst) begin
      phase = 0; s1 = '0; s2 = '0;
      m_level = '0; m_press = '0; m_held = '0;
      for (int i = 0; i < 4; i++) begin run[i] = 0; since[i] = -1; end
    end else begin
      tk     = (phase == DIV - 1);
      phase  = (phase + 1) % DIV;
      sample = s2;
      s2     = s1;
      s1     = btn_raw;
      m_press = '0;
      if (tk) begin
        for (int i = 0; i < 4; i++) begin
          rose = 1'b0;
          if (sample[i] != m_level[i]) begin
            run[i]++;
            if (run[i] == DEB) begin
              run[i] = 0;
              m_level[i] = ~m_level[i];
              if (m_level[i]) begin
                m_press[i] = 1'b1;
                since[i] = 0;
                rose = 1'b1;
              end else begin
                since[i] = -1;
              end
            end
          end else begin
            run[i] = 0;
          end
          if (!rose && m_level[i] && MASK[i]) begin
            since[i]++;
            if (since[i] >= DLY && ((since[i] - DLY) % RATE) == 0) m_press[i] = 1'b1;
          end
        end
      end
      for (int i = 0; i < 4; i++) m_held[i] = MASK[i] && m_level[i] && (since[i] >= DLY);
    end
  end

  task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_vec("level", btn_level, m_level);
    check_vec("press", btn_press, m_press);
    check_vec("held", btn_held, m_held);
    check_vec("pulse_width", prev_press & btn_press, 4'b0);
    prev_press = btn_press;
    held_seen  = held_seen | btn_held;
    for (int i = 0; i < 4; i++) cnt_press[i] += int'(btn_press[i]);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) cnt_press[i] = 0;
    held_seen = 4'b0;
  endtask

  task automatic wait_press(input int b, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      step();
      if (btn_press[b]) ok = 1'b1;
    end
  endtask

  task automatic wait_level(input int b, input logic val, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      step();
      if (btn_level[b] === val) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int t0;
    int h19, h20;
    int b;
    int q[$];
    clear_counts();

    // reset with all buttons held
    btn_raw = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      check_vec("rst_outputs", btn_level | btn_press | btn_held, 4'b0);
    end
    rst = 1'b0;
    clear_counts();
    ok = 1'b0;
    for (int k = 0; k < 18 && !ok; k++) begin
      step();
      if (btn_level === 4'b1111) ok = 1'b1;
    end
    check_int("release_level_all", int'(ok), 1);
    for (int i = 0; i < 4; i++) check_int("release_one_press", cnt_press[i], 1);
    btn_raw = 4'b0;
    steps(30);

    // bounce rejection on bit 0
    clear_counts();
    for (int r = 0; r < 4; r++) begin
      btn_raw[0] = 1'b1; steps(8);
      btn_raw[0] = 1'b0; steps(4);
    end
    check_int("bounce_level", int'(btn_level[0]), 0);
    check_int("bounce_press", cnt_press[0], 0);
    btn_raw[0] = 1'b1;
    steps(20);
    check_int("steady_level", int'(btn_level[0]), 1);
    check_int("steady_press", cnt_press[0], 1);
    btn_raw = 4'b0;
    steps(20);

    // non-repeating button
    clear_counts();
    btn_raw[1] = 1'b1;
    steps(200);
    check_int("norep_press", cnt_press[1], 1);
    check_int("norep_held", int'(held_seen[1]), 0);
    clear_counts();
    btn_raw[1] = 1'b0;
    steps(20);
    check_int("norep_fall_level", int'(btn_level[1]), 0);
    check_int("norep_fall_press", cnt_press[1], 0);

    // auto-repeat timing on bit 2
    clear_counts();
    btn_raw[2] = 1'b1;
    wait_press(2, 40, ok);
    check_int("rep_first_press", int'(ok), 1);
    t0 = cyc; h19 = -1; h20 = -1;
    q.delete();
    for (int k = 0; k < 40; k++) begin
      step();
      if (btn_press[2]) q.push_back(cyc);
      if (cyc == t0 + 19) h19 = int'(btn_held[2]);
      if (cyc == t0 + 20) h20 = int'(btn_held[2]);
    end
    check_int("rep_pulse1", (q.size() > 0) ? q[0] - t0 : -1, 20);
    check_int("rep_pulse2", (q.size() > 1) ? q[1] - t0 : -1, 28);
    check_int("rep_pulse3", (q.size() > 2) ? q[2] - t0 : -1, 36);
    check_int("rep_held_before", h19, 0);
    check_int("rep_held_at", h20, 1);
    btn_raw[2] = 1'b0;
    wait_level(2, 1'b0, 30, ok);
    check_int("rep_fall", int'(ok), 1);
    check_int("rep_fall_held", int'(btn_held[2]), 0);
    clear_counts();
    steps(30);
    check_int("rep_after_fall", cnt_press[2], 0);

    // simultaneous press on bits 3 and 0
    btn_raw = 4'b1001;
    wait_press(3, 40, ok);
    check_int("simul_press3", int'(ok), 1);
    check_int("simul_press0", int'(btn_press[0]), 1);
    clear_counts();
    steps(60);
    check_int("simul_norep0", cnt_press[0], 0);
    check_int("simul_rep3", (cnt_press[3] >= 3) ? 1 : 0, 1);
    btn_raw = 4'b0;
    steps(30);

    // reset while bit 2 repeats
    btn_raw = 4'b0100;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      step();
      if (btn_held[2]) ok = 1'b1;
    end
    check_int("midrst_reach_repeat", int'(ok), 1);
    rst = 1'b1;
    step();
    check_vec("midrst_level", btn_level, 4'b0);
    check_vec("midrst_press", btn_press, 4'b0);
    check_vec("midrst_held", btn_held, 4'b0);
    rst = 1'b0;
    wait_press(2, 40, ok);
    check_int("midrst_new_press", int'(ok), 1);
    t0 = cyc;
    wait_press(2, 40, ok);
    check_int("midrst_first_repeat", ok ? cyc - t0 : -1, 20);
    btn_raw = 4'b0;
    steps(30);

    // random toggles with occasional resets, checked cycle by cycle
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      b = int'($urandom_range(0, 3));
      btn_raw[b] = ~btn_raw[b];
      steps(int'($urandom_range(1, 40)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
